// File: rtl/spm_boot_loader.sv
// ----------------------------------------------------------------------------
// spm_boot_loader
//
// Program/data loader placed in front of the RISC_SPM core and its memory.
// After reset it zero-fills the whole memory, then parses a byte stream of
// load records and writes each record's payload into memory. The core is
// held in reset (cpu_rst_n low) until an end record arrives.
//
// Record format on the stream:
//   <addr> <len> <data 0> ... <data len-1> [<cksum>]
//   len == 0 is the end record; it has no data and no checksum.
//
// Optional feature (compile-time macro LOADER_CKSUM_EN):
//   When defined, every record with len > 0 carries a trailing checksum byte
//   chosen so that addr + len + data bytes + cksum == 0 (mod 256). A bad
//   checksum sets the sticky err flag and parks the loader in an error state
//   with the core still held in reset. When undefined, err is tied to 0.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   in_valid   stream byte valid
//   in_data    stream byte
//   in_ready   loader can accept a byte (transfer = in_valid && in_ready)
//   mem_we     memory write strobe, one word per cycle
//   mem_addr   memory write address
//   mem_wdata  memory write data
//   cpu_rst_n  active-low reset to the core, released once loading completes
//   busy       high while loading is not complete
//   done       loading complete, sticky until rst
//   err        checksum failure, sticky until rst
// ----------------------------------------------------------------------------
module spm_boot_loader #(
    parameter int word_size = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [word_size-1:0] in_data,
    output logic                 in_ready,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [word_size-1:0] mem_wdata,
    output logic                 cpu_rst_n,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    typedef enum logic [2:0] {
        S_FLUSH = 3'd0,
        S_ADDR  = 3'd1,
        S_LEN   = 3'd2,
        S_DATA  = 3'd3,
        S_DONE  = 3'd4
`ifdef LOADER_CKSUM_EN
        ,
        S_CKSUM = 3'd5,
        S_ERROR = 3'd6
`endif
    } state_t;

    // The flush counter is one bit wider than the address so it can count
    // one step past the last address; that extra step is the idle cycle
    // between the last flush write and the first cycle with in_ready high.
    localparam logic [ADDR_W:0] FLUSH_END = (ADDR_W+1)'(MEM_DEPTH);

    state_t                 state_q;
    state_t                 state_nxt;
    logic [ADDR_W:0]        flush_q;
    logic [ADDR_W:0]        flush_nxt;
    logic [ADDR_W-1:0]      ptr_q;
    logic [ADDR_W-1:0]      ptr_nxt;
    logic [word_size-1:0]   cnt_q;
    logic [word_size-1:0]   cnt_nxt;
    logic                   we_nxt;
    logic [ADDR_W-1:0]      addr_nxt;
    logic [word_size-1:0]   wdata_nxt;
    logic                   accept;

`ifdef LOADER_CKSUM_EN
    logic [word_size-1:0]   sum_q;
    logic [word_size-1:0]   sum_nxt;

    // Running checksum: plain modulo-2^word_size addition.
    function automatic logic [word_size-1:0] cksum_add(
        input logic [word_size-1:0] a,
        input logic [word_size-1:0] b
    );
        return a + b;
    endfunction
`endif

    // States in which the loader takes stream bytes.
    function automatic logic takes_bytes(input state_t s);
        logic r;
        r = (s == S_ADDR) || (s == S_LEN) || (s == S_DATA);
`ifdef LOADER_CKSUM_EN
        r = r || (s == S_CKSUM);
`endif
        return r;
    endfunction

    // in_ready is a registered output, so it already reflects the state
    // that will consume the byte on this edge.
    assign accept = in_valid && in_ready;

    // ------------------------------------------------------------------
    // State register and datapath counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FLUSH;
            flush_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
`ifdef LOADER_CKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_nxt;
            flush_q <= flush_nxt;
            ptr_q   <= ptr_nxt;
            cnt_q   <= cnt_nxt;
`ifdef LOADER_CKSUM_EN
            sum_q   <= sum_nxt;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state_q;
        flush_nxt = flush_q;
        ptr_nxt   = ptr_q;
        cnt_nxt   = cnt_q;
        we_nxt    = 1'b0;
        addr_nxt  = mem_addr;
        wdata_nxt = mem_wdata;
`ifdef LOADER_CKSUM_EN
        sum_nxt   = sum_q;
`endif

        case (state_q)
            S_FLUSH: begin
                if (flush_q == FLUSH_END) begin
                    state_nxt = S_ADDR;
                end else begin
                    we_nxt    = 1'b1;
                    addr_nxt  = flush_q[ADDR_W-1:0];
                    wdata_nxt = '0;
                    flush_nxt = flush_q + (ADDR_W+1)'(1);
                end
            end

            S_ADDR: begin
                if (accept) begin
                    ptr_nxt   = ADDR_W'(in_data);
                    state_nxt = S_LEN;
`ifdef LOADER_CKSUM_EN
                    sum_nxt   = in_data;
`endif
                end
            end

            S_LEN: begin
                if (accept) begin
                    cnt_nxt   = in_data;
                    state_nxt = (in_data == '0) ? S_DONE : S_DATA;
`ifdef LOADER_CKSUM_EN
                    sum_nxt   = cksum_add(sum_q, in_data);
`endif
                end
            end

            S_DATA: begin
                if (accept) begin
                    we_nxt    = 1'b1;
                    addr_nxt  = ptr_q;
                    wdata_nxt = in_data;
                    // Pointer wraps naturally at the top of the address space.
                    ptr_nxt   = ptr_q + ADDR_W'(1);
                    cnt_nxt   = cnt_q - word_size'(1);
`ifdef LOADER_CKSUM_EN
                    sum_nxt   = cksum_add(sum_q, in_data);
                    if (cnt_q == word_size'(1)) state_nxt = S_CKSUM;
`else
                    if (cnt_q == word_size'(1)) state_nxt = S_ADDR;
`endif
                end
            end

`ifdef LOADER_CKSUM_EN
            S_CKSUM: begin
                if (accept) begin
                    state_nxt = (cksum_add(sum_q, in_data) == '0) ? S_ADDR : S_ERROR;
                end
            end

            S_ERROR: begin
                state_nxt = S_ERROR;
            end
`endif

            S_DONE: begin
                state_nxt = S_DONE;
            end

            default: begin
                state_nxt = S_FLUSH;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            in_ready  <= 1'b0;
            cpu_rst_n <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b1;
        end else begin
            mem_we    <= we_nxt;
            mem_addr  <= addr_nxt;
            mem_wdata <= wdata_nxt;
            in_ready  <= takes_bytes(state_nxt);
            cpu_rst_n <= (state_nxt == S_DONE);
            done      <= (state_nxt == S_DONE);
            busy      <= (state_nxt != S_DONE);
        end
    end

`ifdef LOADER_CKSUM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else begin
            err <= err || (state_nxt == S_ERROR);
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule
